// File: rtl/divisor_pkg.sv
// divisor_pkg: shared operand width default, core latency helper, result tag record and divide-by-zero result constants
package divisor_pkg;
  localparam int TAMANYO_DEF = 8;
  localparam int IDW_MAX = 3;
  localparam logic [63:0] COC_DZ = '1;
  localparam logic [63:0] RES_DZ = '0;
  typedef struct packed {
    logic valid;
    logic [IDW_MAX-1:0] id;
    logic dz;
  } tag_t;
  function automatic int etapas(input int w);
    return 1 + 2 * w;
  endfunction
endpackage

// File: rtl/divisor_arbitro_if.sv
// divisor_arbitro_if: client bus; master drives enable/req/num/den, slave returns gnt/done/done_id/coc/res/dz/busy
interface divisor_arbitro_if
  import divisor_pkg::*;
#(
  parameter int TAMANYO = TAMANYO_DEF,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
);
  logic enable;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ*TAMANYO-1:0] num;
  logic [NREQ*TAMANYO-1:0] den;
  logic done;
  logic [IDW-1:0] done_id;
  logic [TAMANYO-1:0] coc;
  logic [TAMANYO-1:0] res;
  logic dz;
  logic busy;
  modport master (output enable, req, num, den, input gnt, done, done_id, coc, res, dz, busy);
  modport slave (input enable, req, num, den, output gnt, done, done_id, coc, res, dz, busy);
endinterface

// File: rtl/divisor_nucleo.sv
// divisor_nucleo: unsigned restoring divider pipeline of etapas(TAMANYO) stages, async active-low reset; in clk, rst_n, start, num, den; out done, coc, res
module divisor_nucleo
  import divisor_pkg::*;
#(
  parameter int TAMANYO = TAMANYO_DEF,
  localparam int ETAPAS = etapas(TAMANYO)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TAMANYO-1:0] num,
  input  logic [TAMANYO-1:0] den,
  output logic               done,
  output logic [TAMANYO-1:0] coc,
  output logic [TAMANYO-1:0] res
);
  logic [ETAPAS-1:0] v;
  logic [TAMANYO:0] r [ETAPAS];
  logic [TAMANYO-1:0] n [ETAPAS];
  logic [TAMANYO-1:0] d [ETAPAS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < ETAPAS; i++) begin
        r[i] <= '0;
        n[i] <= '0;
        d[i] <= '0;
      end
    end else begin
      v <= {v[ETAPAS-2:0], start};
      r[0] <= '0;
      n[0] <= num;
      d[0] <= den;
      for (int i = 1; i < ETAPAS; i++) begin
        d[i] <= d[i-1];
        if (i % 2 == 1) {r[i], n[i]} <= {r[i-1][TAMANYO-1:0], n[i-1], 1'b0};
        else if (r[i-1] >= {1'b0, d[i-1]}) begin
          r[i] <= r[i-1] - {1'b0, d[i-1]};
          n[i] <= {n[i-1][TAMANYO-1:1], 1'b1};
        end else begin
          r[i] <= r[i-1];
          n[i] <= n[i-1];
        end
      end
    end
  assign done = v[ETAPAS-1];
  assign coc = n[ETAPAS-1];
  assign res = r[ETAPAS-1][TAMANYO-1:0];
endmodule

// File: rtl/rr_arbitro.sv
// rr_arbitro: round-robin one-hot grant searching upward from ptr; in clk, rst, req, enable; out gnt (combinational), ptr (registered)
module rr_arbitro #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  ptr
);
  logic [IDW-1:0] win;
  logic [IDW-1:0] j;
  logic hit;
  // Walking the offsets downward lets the closest requester to ptr overwrite the others.
  always_comb begin
    hit = 1'b0;
    win = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        hit = 1'b1;
        win = j;
      end
    end
  end
  assign gnt = (enable && hit && !rst) ? NREQ'(1) << win : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (|gnt) ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
endmodule

// File: rtl/divisor_arbitro.sv
// divisor_arbitro: shares one pipelined divider among NREQ requesters; in CLK, RSTa; bus slave: enable, req, num, den -> gnt, done, done_id, coc, res, dz, busy
module divisor_arbitro
  import divisor_pkg::*;
#(
  parameter int TAMANYO = TAMANYO_DEF,
  parameter int NREQ = 4,
  localparam int ETAPAS = etapas(TAMANYO),
  localparam int IDW = $clog2(NREQ)
) (
  input logic CLK,
  input logic RSTa,
  divisor_arbitro_if.slave bus
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] iss_id;
  logic iss_v;
  logic iss_dz;
  logic [TAMANYO-1:0] iss_num;
  logic [TAMANYO-1:0] iss_den;
  logic core_done;
  logic [TAMANYO-1:0] core_coc;
  logic [TAMANYO-1:0] core_res;
  tag_t tags [ETAPAS];
  tag_t fin;
  rr_arbitro #(.NREQ(NREQ)) u_arb (
    .clk(CLK),
    .rst(RSTa),
    .req(bus.req),
    .enable(bus.enable),
    .gnt(bus.gnt),
    .ptr(ptr)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) sel = IDW'(i);
  end
  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) begin
      iss_v <= 1'b0;
      iss_dz <= 1'b0;
      iss_id <= '0;
      iss_num <= '0;
      iss_den <= '0;
    end else begin
      iss_v <= |bus.gnt;
      if (|bus.gnt) begin
        iss_id <= sel;
        iss_num <= bus.num[int'(sel)*TAMANYO +: TAMANYO];
        iss_den <= bus.den[int'(sel)*TAMANYO +: TAMANYO];
        iss_dz <= bus.den[int'(sel)*TAMANYO +: TAMANYO] == '0;
      end
    end
  divisor_nucleo #(.TAMANYO(TAMANYO)) u_core (
    .clk(CLK),
    .rst_n(~RSTa),
    .start(iss_v),
    .num(iss_num),
    .den(iss_den),
    .done(core_done),
    .coc(core_coc),
    .res(core_res)
  );
  // Tag pipeline is exactly as deep as the core so its tail lines up with the core result.
  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) for (int i = 0; i < ETAPAS; i++) tags[i] <= '0;
    else begin
      tags[0] <= '{valid: iss_v, id: IDW_MAX'(iss_id), dz: iss_dz};
      for (int i = 1; i < ETAPAS; i++) tags[i] <= tags[i-1];
    end
  assign fin = tags[ETAPAS-1];
  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) begin
      bus.done <= 1'b0;
      bus.done_id <= '0;
      bus.coc <= '0;
      bus.res <= '0;
      bus.dz <= 1'b0;
    end else begin
      bus.done <= fin.valid;
      if (fin.valid) begin
        bus.done_id <= IDW'(fin.id);
        bus.coc <= fin.dz ? TAMANYO'(COC_DZ) : core_coc;
        bus.res <= fin.dz ? TAMANYO'(RES_DZ) : core_res;
        bus.dz <= fin.dz;
      end
    end
  always_comb begin
    bus.busy = iss_v;
    for (int i = 0; i < ETAPAS; i++) bus.busy = bus.busy | tags[i].valid;
  end
  always @(posedge CLK)
    if (!RSTa) begin
      assert (fin.valid == core_done);
      assert (int'(ptr) < NREQ);
    end
endmodule

// File: doc/divisor_arbitro.md
Name: divisor_arbitro

Overview:
- Shares one pipelined divider core among NREQ requesters.
- A round-robin arbiter accepts at most one divide per cycle and registers the operands into an issue stage.
- The issue stage starts the core; a tag pipeline, exactly as deep as the core, carries the requester ID and divide-by-zero flag.
- Each result appears on a shared result bus with the requester ID attached. The block sits between the client units and the divider core.

Parameters:
- TAMANYO, 8, operand and result width in bits.
- NREQ, 4, number of requesters (2..8).
- ETAPAS, 1+2*TAMANYO, divider core latency in clock edges; derived, never overridden.
- IDW, $clog2(NREQ), width of requester ID.

Ports:
- CLK  input  1  clock, rising edge.
- RSTa  input  1  asynchronous reset, active-high.
- ENABLE  input  1  grants allowed when high.
- REQ  input  NREQ  request per requester, held until granted.
- NUM  input  NREQ*TAMANYO  packed numerators; slice i belongs to requester i.
- DEN  input  NREQ*TAMANYO  packed denominators.
- GNT  output  NREQ  one-hot grant, combinational, same cycle as the accepting edge.
- DONE  output  1  result valid strobe, one cycle.
- DONE_ID  output  IDW  requester owning the result.
- COC  output  TAMANYO  quotient.
- RES  output  TAMANYO  remainder.
- DZ  output  1  divide-by-zero flag for this result.
- BUSY  output  1  at least one operation in the issue stage or in flight.

Behaviour:
- Reset (RSTa=1, asynchronous):
  - Issue register, tag pipeline and divider core are cleared.
  - Round-robin pointer resets to 0.
  - DONE=0, DONE_ID=0, COC=0, RES=0, DZ=0, BUSY=0; GNT=0 while RSTa is high.
  - The core instance takes an active-low reset; drive it with ~RSTa.
  - Reset mid-operation drops every in-flight operation. No DONE is produced for them after release.
- Arbitration:
  - GNT[i]=1 iff ENABLE=1, REQ[i]=1, and i is the first requesting index at or after the pointer, searching upward and wrapping modulo NREQ.
  - At most one grant per cycle.
  - On a grant to i, the pointer becomes (i+1) mod NREQ at the next edge. With no grant, the pointer holds.
  - ENABLE=0: GNT=0, pointer holds. In-flight operations still complete.
- Handshake:
  - The transfer occurs at the rising edge where REQ[i]&GNT[i]=1.
  - The requester may change NUM/DEN or drop REQ only after that edge.
  - A requester keeping REQ high issues back-to-back only when it is the sole requester.
- Issue stage:
  - On a transfer, register NUM_i, DEN_i, ID=i, and dz=(DEN_i==0); set issue_valid=1. With no transfer, issue_valid=0.
  - The core receives START=issue_valid with NUM/DEN from the issue register.
  - In parallel, {valid, ID, dz} enters a tag shift register of depth ETAPAS.
- Latency and throughput:
  - DONE is high exactly ETAPAS+1 edges after the transfer edge (18 for TAMANYO=8).
  - Throughput is one result per cycle. Results return in issue order.
- Output:
  - When the tag valid bit reaches the end of the pipeline, DONE=1 and DONE_ID=tag ID.
  - If dz=0: COC and RES come from the core.
  - If dz=1: COC=all ones, RES=0, DZ=1.
  - When DONE=0, COC, RES, DONE_ID and DZ hold their last values.
  - The core's own DONE is not used for routing; the tag valid bit is authoritative. Assertion: tag valid equals the core DONE every cycle.
- BUSY = issue_valid OR any tag valid bit.
- Simultaneous events: a new transfer on the same edge a result retires is legal and needs no interaction.
- Arithmetic: unsigned only. Quotient and remainder are TAMANYO bits; NUM = COC*DEN + RES holds for every DEN≠0.

Decomposition:
- Package divisor_pkg holds:
  - TAMANYO default and the ETAPAS computation function.
  - Tag struct typedef {valid, id, dz}.
  - Constants COC_DZ='1 and RES_DZ='0.
- Sub-module rr_arbitro (parameter NREQ): inputs REQ, ENABLE; outputs one-hot GNT and the registered pointer.
- The divider core is instantiated unmodified. The tag pipeline and muxing live in the top.

Test Plan:
- Single op: requester 2 issues NUM=100, DEN=7 -> GNT[2] in the request cycle; 18 edges later DONE=1, DONE_ID=2, COC=14, RES=2, DZ=0.
- Divide by zero: requester 0 issues NUM=55, DEN=0 -> after 18 edges DONE=1, DONE_ID=0, COC=255, RES=0, DZ=1.
- Round robin: REQ=4'b1111 held, pointer=0 -> grants in order 0,1,2,3,0 on consecutive cycles. DONE pulses on 5 consecutive cycles with IDs 0,1,2,3,0 and correct quotients.
- Fairness/skip: REQ=4'b1010 with pointer=2 -> grant order 3,1,3,1. ENABLE dropped for 3 cycles -> no GNT, pointer unchanged, in-flight results still retire.
- Reset mid-flight: issue 3 ops, assert RSTa 5 cycles later for 1 cycle -> all outputs 0 immediately, BUSY=0, no DONE in the following 20 cycles.
- Random: 2000 random requests with DEN in 0..255 -> every DONE matches a scoreboard per requester in order. Tag valid equals core DONE throughout; BUSY=0 at quiescence.
